// File: rtl/axi_inst_rom.sv
// Read-only AXI3 burst slave for instruction refills, backed by a word-wide single-port RAM with a backdoor load port.
// Latency: first R beat 2 cycles after the AR handshake, then one beat per cycle; R stalls are absorbed by an output+skid pair.
module axi_inst_rom #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned BIT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    input  logic [31:0]          s_araddr,
    input  logic [7:0]           s_arlen,
    input  logic [2:0]           s_arsize,
    input  logic [1:0]           s_arburst,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic [BIT_WIDTH-1:0] s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 s_rlast,
    input  logic                 load_valid,
    input  logic [31:0]          load_addr,
    input  logic [31:0]          load_data
);
    localparam int unsigned IDXW = $clog2(DEPTH_WORDS);

    typedef enum logic {ST_IDLE, ST_READ} state_t;

    typedef struct packed {
        logic [BIT_WIDTH-1:0] dat;
        logic [1:0]           resp;
        logic                 last;
    } beat_t;

    state_t               r_state;
    logic                 r_arready;
    logic [31:0]          r_addr;
    logic [7:0]           r_len;
    logic [1:0]           r_burst;
    logic                 r_slverr;
    logic [8:0]           r_iss_left;
    logic                 r_p_vld;
    logic [1:0]           r_p_resp;
    logic                 r_p_last;
    logic [BIT_WIDTH-1:0] r_ram_q;
    beat_t                r_o;
    logic                 r_o_vld;
    beat_t                r_s;
    logic                 r_s_vld;
    logic [BIT_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic        w_pop;
    logic [1:0]  w_occ;
    logic [32:0] w_rd_sub;
    logic [32:0] w_ld_sub;
    logic        w_rd_dec;
    logic        w_ld_en;
    logic        w_issue;
    logic [1:0]  w_resp;
    logic [31:0] w_wmask;
    logic [31:0] w_next_addr;
    logic        w_ar_slverr;
    beat_t       w_p_beat;

    // 33-bit subtraction so the borrow flags addresses below the base.
    assign w_rd_sub = {1'b0, r_addr} - {1'b0, ADDR_BASE};
    assign w_ld_sub = {1'b0, load_addr} - {1'b0, ADDR_BASE};
    assign w_rd_dec = w_rd_sub[32] | ((w_rd_sub[31:0] >> 2) >= DEPTH_WORDS);
    assign w_ld_en  = load_valid & ~w_ld_sub[32] & ((w_ld_sub[31:0] >> 2) < DEPTH_WORDS);

    assign w_pop = r_o_vld & s_rready;
    assign w_occ = {1'b0, r_o_vld} + {1'b0, r_s_vld} + {1'b0, r_p_vld};
    // Occupancy never exceeds two, so an in-flight read always has a landing slot.
    assign w_issue = (r_state == ST_READ) & (r_iss_left != 9'd0) & ~w_ld_en
                   & ((w_occ < 2'd2) | w_pop);
    assign w_resp  = r_slverr ? 2'b10 : (w_rd_dec ? 2'b11 : 2'b00);

    assign w_wmask = {22'd0, r_len, 2'b11};
    always_comb begin
        w_next_addr = r_addr + 32'd4;
        case (r_burst)
            2'b00:   w_next_addr = r_addr;
            2'b10:   w_next_addr = (r_addr & ~w_wmask) | ((r_addr + 32'd4) & w_wmask);
            default: w_next_addr = r_addr + 32'd4;
        endcase
    end

    assign w_ar_slverr = (s_arsize != 3'b010) | (s_arburst == 2'b11)
                       | ((s_arburst == 2'b10) & !(s_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

    always_comb begin
        w_p_beat      = '0;
        w_p_beat.dat  = (r_p_resp == 2'b00) ? r_ram_q : '0;
        w_p_beat.resp = r_p_resp;
        w_p_beat.last = r_p_last;
    end

    // RAM has no reset so its contents survive rst; loads win the single port.
    always_ff @(posedge clk) begin
        if (w_ld_en) begin
            r_mem[w_ld_sub[IDXW+1:2]] <= load_data;
        end else if (w_issue && w_resp == 2'b00) begin
            r_ram_q <= r_mem[w_rd_sub[IDXW+1:2]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_arready  <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_burst    <= '0;
            r_slverr   <= 1'b0;
            r_iss_left <= '0;
            r_p_vld    <= 1'b0;
            r_p_resp   <= '0;
            r_p_last   <= 1'b0;
            r_o        <= '0;
            r_o_vld    <= 1'b0;
            r_s        <= '0;
            r_s_vld    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_arready <= ~(s_arvalid & r_arready);
                    if (s_arvalid && r_arready) begin
                        r_state    <= ST_READ;
                        r_addr     <= s_araddr & ~32'd3;
                        r_len      <= s_arlen;
                        r_burst    <= s_arburst;
                        r_slverr   <= w_ar_slverr;
                        r_iss_left <= {1'b0, s_arlen} + 9'd1;
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        r_addr     <= w_next_addr;
                        r_iss_left <= r_iss_left - 9'd1;
                    end
                    if (w_pop && r_o.last) begin
                        r_state   <= ST_IDLE;
                        r_arready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            r_p_vld  <= w_issue;
            r_p_resp <= w_resp;
            r_p_last <= (r_iss_left == 9'd1);

            if (w_pop || !r_o_vld) begin
                if (r_s_vld) begin
                    r_o     <= r_s;
                    r_o_vld <= 1'b1;
                    r_s     <= '0;
                    r_s_vld <= 1'b0;
                end else if (r_p_vld) begin
                    r_o     <= w_p_beat;
                    r_o_vld <= 1'b1;
                end else begin
                    r_o     <= '0;
                    r_o_vld <= 1'b0;
                end
            end else if (r_p_vld) begin
                r_s     <= w_p_beat;
                r_s_vld <= 1'b1;
            end
        end
    end

    assign s_arready = r_arready;
    assign s_rvalid  = r_o_vld;
    assign s_rdata   = r_o.dat;
    assign s_rresp   = r_o.resp;
    assign s_rlast   = r_o.last;
endmodule

// File: tb/tb_axi_inst_rom.sv
// Directed bench for axi_inst_rom: INCR/WRAP/FIXED bursts, R backpressure, DECERR/SLVERR and mid-burst reset.
module tb_axi_inst_rom;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_araddr = '0;
    logic [7:0]  s_arlen = '0;
    logic [2:0]  s_arsize = '0;
    logic [1:0]  s_arburst = '0;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        load_valid = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;

    int n_chk = 0;
    int n_pass = 0;
    int nb, first_k, stall_bad;
    logic [31:0] got_d [16];
    logic [31:0] got_r [16];
    logic [31:0] got_l [16];
    logic [31:0] exp_d [16];
    logic [31:0] exp_r [16];

    axi_inst_rom dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bt);
        int ok;
        ok = 0;
        s_arvalid = 1'b1;
        s_araddr  = a;
        s_arlen   = len;
        s_arsize  = sz;
        s_arburst = bt;
        for (int k = 0; k < 20; k++) begin
            if (s_arready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok != 0) begin
            @(posedge clk); #1;
        end
        s_arvalid = 1'b0;
        chk("ar_accept", 32'(ok), 32'd1);
    endtask

    // Drives rready from a repeating 4-cycle pattern and records every accepted beat.
    task automatic collect(input int n, input logic [3:0] pat);
        logic        hv;
        logic [31:0] hd;
        logic [1:0]  hr;
        logic        hl;
        nb = 0; first_k = -1; stall_bad = 0;
        hv = 1'b0; hd = '0; hr = '0; hl = 1'b0;
        for (int i = 0; i < 16; i++) begin
            got_d[i] = 'x; got_r[i] = 'x; got_l[i] = 'x;
        end
        for (int k = 0; k < 300 && nb < n; k++) begin
            s_rready = pat[2'(k)];
            if (hv && (!s_rvalid || s_rdata !== hd || s_rresp !== hr || s_rlast !== hl))
                stall_bad++;
            hv = 1'b0;
            if (s_rvalid && first_k < 0) first_k = k;
            if (s_rvalid) begin
                if (s_rready) begin
                    got_d[nb] = s_rdata;
                    got_r[nb] = {30'd0, s_rresp};
                    got_l[nb] = {31'd0, s_rlast};
                    nb++;
                end else begin
                    hv = 1'b1; hd = s_rdata; hr = s_rresp; hl = s_rlast;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_beats(input string nm, input int n);
        chk({nm, "_nbeats"}, 32'(nb), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_dat%0d", nm, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_resp%0d", nm, i), got_r[i], exp_r[i]);
            chk($sformatf("%s_last%0d", nm, i), got_l[i], (i == n - 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_rvalid_idle"}, {31'd0, s_rvalid}, 32'd0);
        chk({nm, "_arready_idle"}, {31'd0, s_arready}, 32'd1);
    endtask

    initial begin
        #2 rst = 1'b1;
        #2;
        chk("rst_arready", {31'd0, s_arready}, 32'd0);
        chk("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
        chk("rst_rlast", {31'd0, s_rlast}, 32'd0);
        chk("rst_rresp", {30'd0, s_rresp}, 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_arready_low", {31'd0, s_arready}, 32'd0);
        @(posedge clk); #1;
        chk("rel_arready_high", {31'd0, s_arready}, 32'd1);

        // Words 0..7 hold 0x11,0x22,...,0x88; last word 0xDEADBEEF.
        for (int i = 0; i < 8; i++) load(32'(i * 4), 32'h11 * 32'(i + 1));
        load(32'h3FFC, 32'hDEAD_BEEF);
        load(32'h4000, 32'hFFFF_FFFF);

        // INCR 4 beats, always ready
        ar(32'h0, 8'd3, 3'b010, 2'b01);
        collect(4, 4'b1111);
        chk("incr_first_rvalid", 32'(first_k), 32'd2);
        for (int i = 0; i < 4; i++) begin exp_d[i] = 32'h11 * 32'(i + 1); exp_r[i] = 0; end
        chk_beats("incr", 4);
        chk_idle("incr");

        // WRAP 4 beats from 0x8
        ar(32'h8, 8'd3, 3'b010, 2'b10);
        collect(4, 4'b1111);
        exp_d[0] = 32'h33; exp_d[1] = 32'h44; exp_d[2] = 32'h11; exp_d[3] = 32'h22;
        for (int i = 0; i < 4; i++) exp_r[i] = 0;
        chk_beats("wrap", 4);
        chk_idle("wrap");

        // INCR 8 beats with rready 1,0,0,1
        ar(32'h0, 8'd7, 3'b010, 2'b01);
        collect(8, 4'b1001);
        for (int i = 0; i < 8; i++) begin exp_d[i] = 32'h11 * 32'(i + 1); exp_r[i] = 0; end
        chk_beats("stall", 8);
        chk("stall_stable", 32'(stall_bad), 32'd0);
        chk_idle("stall");

        // FIXED 3 beats at 0x4, unaligned low bits dropped
        ar(32'h6, 8'd2, 3'b010, 2'b00);
        collect(3, 4'b1111);
        for (int i = 0; i < 3; i++) begin exp_d[i] = 32'h22; exp_r[i] = 0; end
        chk_beats("fixed", 3);
        chk_idle("fixed");

        // Top word then out of range
        ar(32'h3FFC, 8'd1, 3'b010, 2'b01);
        collect(2, 4'b1111);
        exp_d[0] = 32'hDEAD_BEEF; exp_r[0] = 32'd0;
        exp_d[1] = 32'h0;         exp_r[1] = 32'd3;
        chk_beats("decerr", 2);
        chk_idle("decerr");

        // Illegal size
        ar(32'h0, 8'd2, 3'b001, 2'b01);
        collect(3, 4'b1111);
        for (int i = 0; i < 3; i++) begin exp_d[i] = 32'h0; exp_r[i] = 32'd2; end
        chk_beats("slverr", 3);
        chk_idle("slverr");

        // Illegal WRAP length
        ar(32'h0, 8'd2, 3'b010, 2'b10);
        collect(3, 4'b1111);
        chk_beats("wraplen", 3);
        chk_idle("wraplen");

        // Reset after beat 2 of an 8-beat burst
        ar(32'h0, 8'd7, 3'b010, 2'b01);
        collect(2, 4'b1111);
        chk("mid_rvalid_pre", {31'd0, s_rvalid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rvalid_rst", {31'd0, s_rvalid}, 32'd0);
        chk("mid_rlast_rst", {31'd0, s_rlast}, 32'd0);
        chk("mid_arready_rst", {31'd0, s_arready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_arready_rel", {31'd0, s_arready}, 32'd0);
        @(posedge clk); #1;
        chk("mid_arready_up", {31'd0, s_arready}, 32'd1);
        ar(32'h0, 8'd3, 3'b010, 2'b01);
        collect(4, 4'b1111);
        for (int i = 0; i < 4; i++) begin exp_d[i] = 32'h11 * 32'(i + 1); exp_r[i] = 0; end
        chk_beats("post_rst", 4);
        chk_idle("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
